// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard unit: scoreboard entry
// layout and the EX forward-select encoding.
package pipe_hazard_ctrl_pkg;

  localparam int SB_RD_W = 5;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               wr;
    logic               load;
  } sb_entry_t;

  // Code 0 reads the register file; code k+1 takes the producer at stage k.
  localparam int FWD_RF   = 0;
  localparam int FWD_MEM1 = 1;

  function automatic int fwd_width(input int mem_stages);
    return $clog2(mem_stages + 2);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline stages and the hazard unit.
// Memory handshake: mem_req_i is held by MEM until mem_gnt_i is seen high in the
// same cycle; every cycle with req high and gnt low freezes the whole pipeline.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int FWD_W  = 2,
  parameter int CNT_W  = 16
);
  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs1_i;
  logic [REG_AW-1:0] id_rs2_i;
  logic              id_rs1_used_i;
  logic              id_rs2_used_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_wr_en_i;
  logic              id_is_load_i;
  logic              ex_redirect_i;
  logic              mem_req_i;
  logic              mem_gnt_i;
  logic              stall_if_o;
  logic              stall_id_o;
  logic              bubble_ex_o;
  logic              flush_o;
  logic              mem_wait_o;
  logic [FWD_W-1:0]  fwd_a_o;
  logic [FWD_W-1:0]  fwd_b_o;
  logic [CNT_W-1:0]  stall_cycles_o;
  logic [CNT_W-1:0]  flush_count_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_wr_en_i, id_is_load_i, ex_redirect_i, mem_req_i, mem_gnt_i,
    input  stall_if_o, stall_id_o, bubble_ex_o, flush_o, mem_wait_o,
           fwd_a_o, fwd_b_o, stall_cycles_o, flush_count_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i,
           id_rd_i, id_wr_en_i, id_is_load_i, ex_redirect_i, mem_req_i, mem_gnt_i,
    output stall_if_o, stall_id_o, bubble_ex_o, flush_o, mem_wait_o,
           fwd_a_o, fwd_b_o, stall_cycles_o, flush_count_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Shift-register scoreboard of in-flight destinations, index 0 = EX through
// MEM_STAGES = last MEM stage, with per-stage source match vectors.
module pipe_hazard_ctrl_scoreboard
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_STAGES = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                shift_en,
  input  logic                bubble,
  input  sb_entry_t           ins,
  input  logic [SB_RD_W-1:0]  rs1,
  input  logic [SB_RD_W-1:0]  rs2,
  input  logic                rs1_used,
  input  logic                rs2_used,
  output logic [MEM_STAGES:0] match_a,
  output logic [MEM_STAGES:0] match_b,
  output logic                load_hit
);

  sb_entry_t sb [0:MEM_STAGES];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= MEM_STAGES; k++) sb[k] <= '0;
    end else if (shift_en) begin
      sb[0] <= bubble ? '0 : ins;
      for (int k = 0; k < MEM_STAGES; k++) sb[k+1] <= sb[k];
    end
  end

  // A load still short of the last MEM stage cannot supply data yet.
  always_comb begin
    match_a  = '0;
    match_b  = '0;
    load_hit = 1'b0;
    for (int k = 0; k <= MEM_STAGES; k++) begin
      match_a[k] = rs1_used && sb[k].valid && sb[k].wr && (sb[k].rd == rs1);
      match_b[k] = rs2_used && sb[k].valid && sb[k].wr && (sb[k].rd == rs2);
      if (k < MEM_STAGES && sb[k].load && (match_a[k] || match_b[k])) load_hit = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard unit: priority freeze > flush > load-use > advance, registered
// EX forward selects and saturating stall/flush counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_STAGES = 1,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 16,
  parameter int FWD_W      = fwd_width(MEM_STAGES)
) (
  input logic               clock,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  logic [MEM_STAGES:0] match_a, match_b;
  logic                load_hit;
  logic                freeze, redirect, load_use, kill;
  logic [REG_AW-1:0]   id_rd;
  sb_entry_t           ins;
  logic [FWD_W-1:0]    fwd_a_q, fwd_b_q;
  logic [CNT_W-1:0]    stall_cnt_q, flush_cnt_q;

  function automatic logic [FWD_W-1:0] fwd_enc(input logic [MEM_STAGES:0] m);
    fwd_enc = FWD_W'(FWD_RF);
    for (int k = MEM_STAGES; k >= 0; k--) if (m[k]) fwd_enc = FWD_W'(FWD_MEM1 + k);
  endfunction

  // Reset gates the decode so every output reads 0 as soon as reset asserts.
  assign freeze   = reset && bus.mem_req_i && !bus.mem_gnt_i;
  assign redirect = reset && !freeze && bus.ex_redirect_i;
  assign load_use = reset && !freeze && !redirect && bus.id_valid_i && load_hit;
  assign kill     = redirect || load_use;

  assign id_rd      = bus.id_rd_i;
  assign ins.valid  = bus.id_valid_i;
  assign ins.rd     = id_rd;
  assign ins.wr     = bus.id_wr_en_i && (id_rd != '0);
  assign ins.load   = bus.id_is_load_i;

  pipe_hazard_ctrl_scoreboard #(.MEM_STAGES(MEM_STAGES)) u_sb (
    .clock    (clock),
    .reset    (reset),
    .shift_en (!freeze),
    .bubble   (kill),
    .ins      (ins),
    .rs1      (bus.id_rs1_i),
    .rs2      (bus.id_rs2_i),
    .rs1_used (bus.id_rs1_used_i),
    .rs2_used (bus.id_rs2_used_i),
    .match_a  (match_a),
    .match_b  (match_b),
    .load_hit (load_hit)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!freeze) begin
        fwd_a_q <= kill ? '0 : fwd_enc(match_a);
        fwd_b_q <= kill ? '0 : fwd_enc(match_b);
      end
      if ((freeze || load_use) && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.mem_wait_o     = freeze;
  assign bus.stall_if_o     = freeze || load_use;
  assign bus.stall_id_o     = freeze || load_use;
  assign bus.bubble_ex_o    = load_use;
  assign bus.flush_o        = redirect;
  assign bus.fwd_a_o        = fwd_a_q;
  assign bus.fwd_b_o        = fwd_b_q;
  assign bus.stall_cycles_o = stall_cnt_q;
  assign bus.flush_count_o  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: M=1 and M=2 instances plus a narrow
// counter instance, all driven from one shared stimulus set.
module tb_pipe_hazard_ctrl;

  logic       clock;
  logic       reset;
  logic       id_valid, rs1_used, rs2_used, wr_en, is_load;
  logic [4:0] rs1, rs2, rd;
  logic       redirect, mem_req, mem_gnt;
  int         n_checks;
  int         n_fail;

  pipe_hazard_ctrl_if #(.REG_AW(5), .FWD_W(2), .CNT_W(16)) if1 ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .FWD_W(2), .CNT_W(16)) if2 ();
  pipe_hazard_ctrl_if #(.REG_AW(5), .FWD_W(2), .CNT_W(3))  if3 ();

  assign if1.id_valid_i = id_valid;  assign if1.id_rs1_i = rs1;  assign if1.id_rs2_i = rs2;
  assign if1.id_rs1_used_i = rs1_used;  assign if1.id_rs2_used_i = rs2_used;
  assign if1.id_rd_i = rd;  assign if1.id_wr_en_i = wr_en;  assign if1.id_is_load_i = is_load;
  assign if1.ex_redirect_i = redirect;  assign if1.mem_req_i = mem_req;  assign if1.mem_gnt_i = mem_gnt;

  assign if2.id_valid_i = id_valid;  assign if2.id_rs1_i = rs1;  assign if2.id_rs2_i = rs2;
  assign if2.id_rs1_used_i = rs1_used;  assign if2.id_rs2_used_i = rs2_used;
  assign if2.id_rd_i = rd;  assign if2.id_wr_en_i = wr_en;  assign if2.id_is_load_i = is_load;
  assign if2.ex_redirect_i = redirect;  assign if2.mem_req_i = mem_req;  assign if2.mem_gnt_i = mem_gnt;

  assign if3.id_valid_i = id_valid;  assign if3.id_rs1_i = rs1;  assign if3.id_rs2_i = rs2;
  assign if3.id_rs1_used_i = rs1_used;  assign if3.id_rs2_used_i = rs2_used;
  assign if3.id_rd_i = rd;  assign if3.id_wr_en_i = wr_en;  assign if3.id_is_load_i = is_load;
  assign if3.ex_redirect_i = redirect;  assign if3.mem_req_i = mem_req;  assign if3.mem_gnt_i = mem_gnt;

  pipe_hazard_ctrl #(.MEM_STAGES(1), .REG_AW(5), .CNT_W(16)) dut1 (.clock(clock), .reset(reset), .bus(if1));
  pipe_hazard_ctrl #(.MEM_STAGES(2), .REG_AW(5), .CNT_W(16)) dut2 (.clock(clock), .reset(reset), .bus(if2));
  pipe_hazard_ctrl #(.MEM_STAGES(1), .REG_AW(5), .CNT_W(3))  dut3 (.clock(clock), .reset(reset), .bus(if3));

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic u1, input logic u2, input logic [4:0] d,
                        input logic w, input logic ld);
    id_valid = v; rs1 = s1; rs2 = s2; rs1_used = u1; rs2_used = u2;
    rd = d; wr_en = w; is_load = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    redirect = 1'b0; mem_req = 1'b0; mem_gnt = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle();
    reset = 1'b0;
    mem_req = 1'b1; redirect = 1'b1;
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1);
    tick();
    n_checks++; if (if1.mem_wait_o !== 1'b0) begin n_fail++; $display("FAIL rst_mem_wait: got %0d expected 0", if1.mem_wait_o); end
    n_checks++; if (if1.flush_o !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %0d expected 0", if1.flush_o); end
    n_checks++; if (if1.stall_if_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall_if: got %0d expected 0", if1.stall_if_o); end
    idle();
    tick();
    reset = 1'b1;
    #1;
    n_checks++; if (if1.stall_id_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall_id: got %0d expected 0", if1.stall_id_o); end
    n_checks++; if (if1.bubble_ex_o !== 1'b0) begin n_fail++; $display("FAIL rst_bubble: got %0d expected 0", if1.bubble_ex_o); end
    n_checks++; if (if1.fwd_a_o !== 2'd0) begin n_fail++; $display("FAIL rst_fwd_a: got %0d expected 0", if1.fwd_a_o); end
    n_checks++; if (if1.fwd_b_o !== 2'd0) begin n_fail++; $display("FAIL rst_fwd_b: got %0d expected 0", if1.fwd_b_o); end
    n_checks++; if (if1.stall_cycles_o !== 16'd0) begin n_fail++; $display("FAIL rst_stall_cnt: got %0d expected 0", if1.stall_cycles_o); end
    n_checks++; if (if1.flush_count_o !== 16'd0) begin n_fail++; $display("FAIL rst_flush_cnt: got %0d expected 0", if1.flush_count_o); end
  endtask

  task automatic test_load_use_m1();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);      // lw x5
    #1;
    n_checks++; if (if1.stall_id_o !== 1'b0) begin n_fail++; $display("FAIL lu1_lw_stall: got %0d expected 0", if1.stall_id_o); end
    tick();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);      // add x6,x5,x1
    #1;
    n_checks++; if (if1.stall_id_o !== 1'b1) begin n_fail++; $display("FAIL lu1_stall_id: got %0d expected 1", if1.stall_id_o); end
    n_checks++; if (if1.stall_if_o !== 1'b1) begin n_fail++; $display("FAIL lu1_stall_if: got %0d expected 1", if1.stall_if_o); end
    n_checks++; if (if1.bubble_ex_o !== 1'b1) begin n_fail++; $display("FAIL lu1_bubble: got %0d expected 1", if1.bubble_ex_o); end
    tick();
    #1;
    n_checks++; if (if1.stall_id_o !== 1'b0) begin n_fail++; $display("FAIL lu1_release: got %0d expected 0", if1.stall_id_o); end
    tick();
    idle();
    #1;
    n_checks++; if (if1.fwd_a_o !== 2'd2) begin n_fail++; $display("FAIL lu1_fwd_a: got %0d expected 2", if1.fwd_a_o); end
    n_checks++; if (if1.fwd_b_o !== 2'd0) begin n_fail++; $display("FAIL lu1_fwd_b: got %0d expected 0", if1.fwd_b_o); end
    n_checks++; if (if1.stall_cycles_o !== 16'd1) begin n_fail++; $display("FAIL lu1_stall_cnt: got %0d expected 1", if1.stall_cycles_o); end
  endtask

  task automatic test_forward_m1();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);      // add x5
    tick();
    set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);      // sub x7,x1,x5
    #1;
    n_checks++; if (if1.stall_id_o !== 1'b0) begin n_fail++; $display("FAIL fw_no_stall: got %0d expected 0", if1.stall_id_o); end
    tick();
    idle();
    #1;
    n_checks++; if (if1.fwd_b_o !== 2'd1) begin n_fail++; $display("FAIL fw_fwd_b: got %0d expected 1", if1.fwd_b_o); end
    n_checks++; if (if1.fwd_a_o !== 2'd0) begin n_fail++; $display("FAIL fw_fwd_a: got %0d expected 0", if1.fwd_a_o); end
    tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);      // add x0
    tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);      // sub x7,x1,x0
    tick();
    idle();
    #1;
    n_checks++; if (if1.fwd_b_o !== 2'd0) begin n_fail++; $display("FAIL fw_x0_fwd_b: got %0d expected 0", if1.fwd_b_o); end
  endtask

  task automatic test_load_use_m2();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1);      // lw x3
    tick();
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0);      // or x4,x3,x3
    #1;
    n_checks++; if (if2.stall_id_o !== 1'b1) begin n_fail++; $display("FAIL lu2_stall1: got %0d expected 1", if2.stall_id_o); end
    n_checks++; if (if2.bubble_ex_o !== 1'b1) begin n_fail++; $display("FAIL lu2_bubble1: got %0d expected 1", if2.bubble_ex_o); end
    tick();
    #1;
    n_checks++; if (if2.stall_id_o !== 1'b1) begin n_fail++; $display("FAIL lu2_stall2: got %0d expected 1", if2.stall_id_o); end
    tick();
    #1;
    n_checks++; if (if2.stall_id_o !== 1'b0) begin n_fail++; $display("FAIL lu2_release: got %0d expected 0", if2.stall_id_o); end
    tick();
    idle();
    #1;
    n_checks++; if (if2.fwd_a_o !== 2'd3) begin n_fail++; $display("FAIL lu2_fwd_a: got %0d expected 3", if2.fwd_a_o); end
    n_checks++; if (if2.fwd_b_o !== 2'd3) begin n_fail++; $display("FAIL lu2_fwd_b: got %0d expected 3", if2.fwd_b_o); end
    n_checks++; if (if2.stall_cycles_o !== 16'd2) begin n_fail++; $display("FAIL lu2_stall_cnt: got %0d expected 2", if2.stall_cycles_o); end
  endtask

  task automatic test_flush_over_load_use();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);      // lw x5
    tick();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);      // add x6,x5,x1 (killed)
    redirect = 1'b1;
    #1;
    n_checks++; if (if1.flush_o !== 1'b1) begin n_fail++; $display("FAIL fl_flush: got %0d expected 1", if1.flush_o); end
    n_checks++; if (if1.stall_id_o !== 1'b0) begin n_fail++; $display("FAIL fl_stall_id: got %0d expected 0", if1.stall_id_o); end
    n_checks++; if (if1.bubble_ex_o !== 1'b0) begin n_fail++; $display("FAIL fl_bubble: got %0d expected 0", if1.bubble_ex_o); end
    tick();
    redirect = 1'b0;
    set_id(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);      // xor x8,x6,x6
    #1;
    n_checks++; if (if1.flush_count_o !== 16'd1) begin n_fail++; $display("FAIL fl_flush_cnt: got %0d expected 1", if1.flush_count_o); end
    n_checks++; if (if1.fwd_a_o !== 2'd0) begin n_fail++; $display("FAIL fl_fwd_zero: got %0d expected 0", if1.fwd_a_o); end
    tick();
    idle();
    #1;
    n_checks++; if (if1.fwd_a_o !== 2'd0) begin n_fail++; $display("FAIL fl_sb_bubble: got %0d expected 0", if1.fwd_a_o); end
    n_checks++; if (if1.stall_cycles_o !== 16'd0) begin n_fail++; $display("FAIL fl_stall_cnt: got %0d expected 0", if1.stall_cycles_o); end
  endtask

  task automatic test_freeze_redirect();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);      // add x5
    tick();
    set_id(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);      // sub x7,x1,x5
    tick();
    set_id(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);      // reads x7
    mem_req = 1'b1; mem_gnt = 1'b0; redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (if1.mem_wait_o !== 1'b1) begin n_fail++; $display("FAIL fz_mem_wait[%0d]: got %0d expected 1", i, if1.mem_wait_o); end
      n_checks++; if (if1.flush_o !== 1'b0) begin n_fail++; $display("FAIL fz_flush[%0d]: got %0d expected 0", i, if1.flush_o); end
      n_checks++; if (if1.stall_id_o !== 1'b1 || if1.bubble_ex_o !== 1'b0) begin n_fail++; $display("FAIL fz_stall[%0d]: got %0d/%0d expected 1/0", i, if1.stall_id_o, if1.bubble_ex_o); end
      n_checks++; if (if1.fwd_b_o !== 2'd1 || if1.fwd_a_o !== 2'd0) begin n_fail++; $display("FAIL fz_fwd_hold[%0d]: got %0d/%0d expected 0/1", i, if1.fwd_a_o, if1.fwd_b_o); end
      tick();
    end
    mem_gnt = 1'b1;
    #1;
    n_checks++; if (if1.flush_o !== 1'b1) begin n_fail++; $display("FAIL fz_flush_late: got %0d expected 1", if1.flush_o); end
    n_checks++; if (if1.mem_wait_o !== 1'b0) begin n_fail++; $display("FAIL fz_unfrozen: got %0d expected 0", if1.mem_wait_o); end
    tick();
    idle();
    #1;
    n_checks++; if (if1.stall_cycles_o !== 16'd3) begin n_fail++; $display("FAIL fz_stall_cnt: got %0d expected 3", if1.stall_cycles_o); end
    n_checks++; if (if1.flush_count_o !== 16'd1) begin n_fail++; $display("FAIL fz_flush_cnt: got %0d expected 1", if1.flush_count_o); end
    n_checks++; if (if1.fwd_b_o !== 2'd0) begin n_fail++; $display("FAIL fz_fwd_cleared: got %0d expected 0", if1.fwd_b_o); end
  endtask

  task automatic test_reset_mid_freeze();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);      // lw x5
    tick();
    set_id(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0);      // add x6,x5,x1
    mem_req = 1'b1; mem_gnt = 1'b0;
    #1;
    n_checks++; if (if1.bubble_ex_o !== 1'b0 || if1.mem_wait_o !== 1'b1) begin n_fail++; $display("FAIL rmf_freeze_prio: got %0d/%0d expected 0/1", if1.bubble_ex_o, if1.mem_wait_o); end
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (if1.mem_wait_o !== 1'b0 || if1.stall_id_o !== 1'b0 || if1.stall_if_o !== 1'b0) begin n_fail++; $display("FAIL rmf_comb_zero: got %0d%0d%0d expected 000", if1.mem_wait_o, if1.stall_id_o, if1.stall_if_o); end
    n_checks++; if (if1.stall_cycles_o !== 16'd0) begin n_fail++; $display("FAIL rmf_cnt_zero: got %0d expected 0", if1.stall_cycles_o); end
    mem_req = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (if1.stall_id_o !== 1'b0) begin n_fail++; $display("FAIL rmf_no_stall: got %0d expected 0", if1.stall_id_o); end
    tick();
    idle();
    #1;
    n_checks++; if (if1.fwd_a_o !== 2'd0) begin n_fail++; $display("FAIL rmf_fwd_a: got %0d expected 0", if1.fwd_a_o); end
  endtask

  task automatic test_saturation();
    do_reset();
    mem_req = 1'b1; mem_gnt = 1'b0;
    repeat (10) tick();
    mem_req = 1'b0;
    #1;
    n_checks++; if (if3.stall_cycles_o !== 3'd7) begin n_fail++; $display("FAIL sat_stall: got %0d expected 7", if3.stall_cycles_o); end
    n_checks++; if (if1.stall_cycles_o !== 16'd10) begin n_fail++; $display("FAIL wide_stall: got %0d expected 10", if1.stall_cycles_o); end
    redirect = 1'b1;
    repeat (10) tick();
    redirect = 1'b0;
    #1;
    n_checks++; if (if3.flush_count_o !== 3'd7) begin n_fail++; $display("FAIL sat_flush: got %0d expected 7", if3.flush_count_o); end
    n_checks++; if (if3.stall_cycles_o !== 3'd7) begin n_fail++; $display("FAIL sat_stall_hold: got %0d expected 7", if3.stall_cycles_o); end
    n_checks++; if (if1.flush_count_o !== 16'd10) begin n_fail++; $display("FAIL wide_flush: got %0d expected 10", if1.flush_count_o); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    idle();
    test_reset();
    test_load_use_m1();
    test_forward_m1();
    test_load_use_m2();
    test_flush_over_load_use();
    test_freeze_redirect();
    test_reset_mid_freeze();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
